// File: rtl/common_pkg.sv
// Shared types for the core memory path: access kinds and load/store unit FSM states.
package common;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        LB       = 4'd1,
        LH       = 4'd2,
        LW       = 4'd3,
        LBU      = 4'd4,
        LHU      = 4'd5,
        SB       = 4'd6,
        SH       = 4'd7,
        SW       = 4'd8
    } mem_access_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    function automatic logic is_store(input mem_access_type t);
        return (t == SB) || (t == SH) || (t == SW);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the load/store unit: strobes, store replication, load extraction, misalign check.
// Purely combinational; no latency, no flow control.
module lsu_align
    import common::*;
(
    input  mem_access_type req_type,
    input  logic [1:0]     req_offset,
    output logic           req_misaligned,
    input  mem_access_type mem_type,
    input  logic [1:0]     offset,
    input  logic [31:0]    wdata,
    input  logic [31:0]    bus_rdata,
    output logic [3:0]     strb,
    output logic [31:0]    bus_wdata,
    output logic [31:0]    load_data
);

    logic [31:0] shifted;

    always_comb begin
        req_misaligned = 1'b0;
        case (req_type)
            LH, LHU, SH: req_misaligned = req_offset[0];
            LW, SW:      req_misaligned = (req_offset != 2'b00);
            default:     req_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        strb      = 4'b0000;
        bus_wdata = wdata;
        case (mem_type)
            SB: begin
                strb      = 4'b0001 << offset;
                bus_wdata = {4{wdata[7:0]}};
            end
            SH: begin
                strb      = 4'b0011 << offset;
                bus_wdata = {2{wdata[15:0]}};
            end
            SW: begin
                strb      = 4'b1111;
                bus_wdata = wdata;
            end
            default: begin
                strb      = 4'b0000;
                bus_wdata = wdata;
            end
        endcase
    end

    always_comb begin
        shifted   = bus_rdata >> {offset, 3'b000};
        load_data = 32'd0;
        case (mem_type)
            LB:      load_data = {{24{shifted[7]}}, shifted[7:0]};
            LBU:     load_data = {24'd0, shifted[7:0]};
            LH:      load_data = {{16{shifted[15]}}, shifted[15:0]};
            LHU:     load_data = {16'd0, shifted[15:0]};
            LW:      load_data = shifted;
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding memory op between execute stage and data bus.
// Latency: accept->resp 3 cycles minimum (1 for misaligned); req_ready only in IDLE, dbus_req held until gnt.
module load_store_unit
    import common::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  mem_access_type        mem_type,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  resp_valid,
    output logic [31:0]           rdata,
    output logic                  misaligned,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [ADDR_WIDTH-1:0] dbus_addr,
    output logic [31:0]           dbus_wdata,
    output logic [3:0]            dbus_strb,
    input  logic                  dbus_gnt,
    input  logic                  dbus_rvalid,
    input  logic [31:0]           dbus_rdata
);

    lsu_state_t            state;
    mem_access_type        lat_type;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [31:0]           lat_wdata;

    logic                  req_misaligned;
    logic [3:0]            align_strb;
    logic [31:0]           align_wdata;
    logic [31:0]           load_data;

    lsu_align u_align (
        .req_type       (mem_type),
        .req_offset     (addr[1:0]),
        .req_misaligned (req_misaligned),
        .mem_type       (lat_type),
        .offset         (lat_addr[1:0]),
        .wdata          (lat_wdata),
        .bus_rdata      (dbus_rdata),
        .strb           (align_strb),
        .bus_wdata      (align_wdata),
        .load_data      (load_data)
    );

    assign req_ready  = (state == IDLE);
    assign dbus_req   = (state == REQ);
    assign dbus_we    = (state == REQ) && is_store(lat_type);
    assign dbus_strb  = (state == REQ) ? align_strb : 4'b0000;
    assign dbus_addr  = {lat_addr[ADDR_WIDTH-1:2], 2'b00};
    assign dbus_wdata = align_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lat_type   <= MEM_NONE;
            lat_addr   <= '0;
            lat_wdata  <= 32'd0;
            resp_valid <= 1'b0;
            rdata      <= 32'd0;
            misaligned <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && (mem_type != MEM_NONE)) begin
                        lat_type  <= mem_type;
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        // Misaligned ops skip the bus entirely and respond next cycle.
                        if (req_misaligned) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            misaligned <= 1'b1;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dbus_gnt) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (dbus_rvalid) begin
                        rdata      <= load_data;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    misaligned <= 1'b0;
                    rdata      <= 32'd0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, byte-address width of addr and dbus_addr.
REQ-002 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: req_valid  in  1  execute stage presents a memory operation.
REQ-005 Port: req_ready  out  1  unit can accept a request this cycle.
REQ-006 Port: mem_type  in  mem_access_type  LB/LH/LW/LBU/LHU/SB/SH/SW/MEM_NONE.
REQ-007 Port: addr  in  ADDR_WIDTH  effective byte address.
REQ-008 Port: wdata  in  32  store data, right-aligned.
REQ-009 Port: resp_valid  out  1  one-cycle pulse; operation finished.
REQ-010 Port: rdata  out  32  load result, extended; 0 for stores and misaligned operations.
REQ-011 Port: misaligned  out  1  qualifies resp_valid; operation rejected, no bus access.
REQ-012 Port: dbus_req / dbus_we  out  1 / 1  bus request; write enable.
REQ-013 Port: dbus_addr  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0.
REQ-014 Port: dbus_wdata / dbus_strb  out  32 / 4  lane-replicated data; byte strobes (0 for loads).
REQ-015 Port: dbus_gnt / dbus_rvalid  in  1 / 1  request accepted; read data or write ack.
REQ-016 Port: dbus_rdata  in  32  read word.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-018 IDLE: req_valid with mem_type = MEM_NONE is ignored; no response.
REQ-019 IDLE: accepted request latches mem_type, addr, wdata; go to REQ, or to RESP with misaligned flag if misaligned.
REQ-020 Misaligned: LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] != 0; bytes never misaligned.
REQ-021 REQ: dbus_req = 1, with dbus_we/addr/wdata/strb held stable until the cycle dbus_gnt = 1, then go to WAIT.
REQ-022 WAIT: dbus_req = 0; on dbus_rvalid, register extracted data and go to RESP.
REQ-023 dbus_rvalid is ignored outside WAIT; the bus never returns rvalid in the same cycle as gnt.
REQ-024 RESP: resp_valid = 1 for exactly one cycle; then IDLE.
REQ-025 Minimum latency: accept at cycle 0, gnt at 1, rvalid at 2, resp_valid at 3; next accept at 4.
REQ-026 Misaligned latency: accept at cycle 0, resp_valid = 1 and misaligned = 1 at cycle 1.
REQ-027 Strobes: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111.
REQ-028 Store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-029 Load data: dbus_rdata >> (8*addr[1:0]); LB/LH sign-extend; LBU/LHU zero-extend; LW unchanged.
REQ-030 rdata and misaligned are valid only while resp_valid = 1 and are held at 0 otherwise.

Reset
REQ-031 rst asserted forces IDLE immediately (asynchronously), including mid-transaction.
REQ-032 Reset values: dbus_req = 0, resp_valid = 0, misaligned = 0, rdata = 0, dbus_strb = 0, latched request cleared.
REQ-033 req_ready = 1 from the first cycle after rst deasserts; a stale dbus_rvalid after reset produces no response.

Structure
REQ-034 Shared package common gains lsu_state_t (IDLE/REQ/WAIT/RESP); mem_access_type is reused from common.
REQ-035 Strobe generation, store replication, load extraction and misalignment detection live in combinational sub-module lsu_align.
REQ-036 load_store_unit holds only the FSM, request latches and response register.

Verification
REQ-037 LW addr=0x100, gnt at cycle 1, rvalid at 2, dbus_rdata=0xDEADBEEF -> dbus_addr=0x100, strb=0, resp_valid at 3, rdata=0xDEADBEEF.
REQ-038 LB addr=0x103, dbus_rdata=0x80000000 -> rdata=0xFFFFFF80; LBU same access -> rdata=0x00000080.
REQ-039 SH addr=0x202, wdata=0x1234ABCD -> dbus_we=1, dbus_addr=0x200, strb=4'b1100, dbus_wdata=0xABCDABCD; rdata=0 at resp.
REQ-040 LW addr=0x101 -> no dbus_req, resp_valid and misaligned = 1 at cycle 1, rdata=0.
REQ-041 gnt withheld 5 cycles -> dbus_req and all dbus outputs stable for all 5 cycles, req_ready=0 throughout.
REQ-042 rst pulsed in WAIT, then dbus_rvalid arrives -> no resp_valid, req_ready=1 the cycle after rst deasserts.
